inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum WAIT/DROP cycles without imem_ack before error.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pc_in  input  32  current byte address from PC stage.
REQ-005 flush  input  1  taken jump; discard in-flight/held instruction.
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  32  latched fetch address.
REQ-008 imem_ack  input  1  read complete; imem_rdata valid this cycle.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 inst_valid  output  1  inst_out/inst_pc valid to decode.
REQ-011 inst_ready  input  1  decode accepts instruction.
REQ-012 inst_out  output  32  fetched instruction.
REQ-013 inst_pc  output  32  address inst_out was fetched from.
REQ-014 fetch_stall  output  1  PC must hold; high in every state except IDLE.
REQ-015 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, DROP, FULL, ERR.
REQ-017 IDLE: next cycle -> WAIT; imem_addr <= pc_in; timeout counter <= 0.
REQ-018 WAIT: imem_req=1, held until ack. On imem_ack and !flush -> FULL; inst_out <= imem_rdata; inst_pc <= imem_addr.
REQ-019 Latency: inst_valid rises the cycle after the imem_ack cycle; ack in the first WAIT cycle is legal (minimum 2 cycles from WAIT entry to inst_valid).
REQ-020 FULL: inst_valid=1, imem_req=0; inst_out/inst_pc SHALL stay stable while inst_valid & !inst_ready.
REQ-021 FULL with inst_valid & inst_ready -> WAIT next cycle; imem_addr <= pc_in; counter cleared.
REQ-022 flush in WAIT without ack -> DROP; imem_req stays 1 until ack (no request withdrawal).
REQ-023 flush in WAIT with same-cycle ack -> data discarded; WAIT re-entered; imem_addr <= pc_in.
REQ-024 DROP: on imem_ack, data discarded -> WAIT; imem_addr <= pc_in. flush in DROP has no further effect.
REQ-025 flush in FULL -> inst_valid drops next cycle; WAIT; imem_addr <= pc_in; flush overrides a simultaneous inst_ready handshake (instruction not consumed).
REQ-026 Timeout counter: 0 on WAIT/DROP entry, +1 per cycle without ack; saturates at TIMEOUT.
REQ-027 Counter reaching TIMEOUT -> ERR; fetch_err=1, imem_req=0, inst_valid=0; ERR exits only via rst.
REQ-028 imem_addr SHALL change only on WAIT entry; never while imem_req=1.

Reset
REQ-029 rst asserted: state=IDLE; imem_req=0, inst_valid=0, fetch_err=0, inst_out=0, inst_pc=0, imem_addr=0, counter=0, all immediately (asynchronous).
REQ-030 rst mid-transaction: outstanding request abandoned; a late imem_ack after deassertion, arriving in IDLE, SHALL be ignored.
REQ-031 fetch_stall SHALL be 0 during reset.

Structure
REQ-032 State encoding constants and the 32-bit instruction NOP value (0) SHALL live in shared package cpu_defs.
REQ-033 Timeout counter SHALL be sub-module fetch_timer (clear, enable, TIMEOUT parameter, expired output).

Verification
REQ-034 Reset release, pc_in=0x00, ack after 1 WAIT cycle, rdata=0x8C010004, inst_ready=1 -> inst_valid one cycle after ack, inst_out=0x8C010004, inst_pc=0x00.
REQ-035 inst_ready=0 for 5 cycles in FULL -> inst_out/inst_pc stable, imem_req=0, fetch_stall=1; handshake -> WAIT with imem_addr=current pc_in.
REQ-036 flush 2 cycles into WAIT, ack 3 cycles later with 0xDEADBEEF -> never presented; next fetch from new pc_in=0x40 delivers its own data.
REQ-037 flush and imem_ack in same cycle -> data discarded, WAIT re-entered with new pc_in, no inst_valid pulse.
REQ-038 TIMEOUT=4, ack never given -> fetch_err=1 after 4 WAIT cycles, imem_req=0; stays until rst.
REQ-039 rst pulsed mid-WAIT, ack arrives in IDLE -> ignored, inst_valid stays 0, normal fetch resumes.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM state encoding and the NOP instruction word.
package cpu_defs;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DROP = 3'd2,
        ST_FULL = 3'd3,
        ST_ERR  = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // A memory read is outstanding in both the normal and the discarding wait.
    function automatic logic req_state(input fetch_state_t s);
        return (s == ST_WAIT) || (s == ST_DROP);
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating wait-cycle counter guarding an outstanding instruction memory read.
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
    localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // One more unacknowledged cycle brings the count to TIMEOUT.
    assign expired = (count == LAST);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem read, a one-entry output
// buffer towards decode, flush handling and a sticky memory-timeout error.
module inst_fetch
    import cpu_defs::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_stall,
    output logic        fetch_err
);

    fetch_state_t state, state_next;
    logic         load_addr;
    logic         capture;
    logic         timer_clear;
    logic         timer_en;
    logic         timer_expired;

    fetch_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        state_next  = state;
        load_addr   = 1'b0;
        capture     = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                state_next  = ST_WAIT;
                load_addr   = 1'b1;
                timer_clear = 1'b1;
            end

            ST_WAIT: begin
                if (imem_ack) begin
                    if (flush) begin
                        // Returning word belongs to the abandoned path.
                        load_addr   = 1'b1;
                        timer_clear = 1'b1;
                    end else begin
                        state_next = ST_FULL;
                        capture    = 1'b1;
                    end
                end else if (flush) begin
                    // The request cannot be withdrawn; wait it out in DROP.
                    state_next  = ST_DROP;
                    timer_clear = 1'b1;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expired) begin
                        state_next = ST_ERR;
                    end
                end
            end

            ST_DROP: begin
                if (imem_ack) begin
                    state_next  = ST_WAIT;
                    load_addr   = 1'b1;
                    timer_clear = 1'b1;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expired) begin
                        state_next = ST_ERR;
                    end
                end
            end

            ST_FULL: begin
                // flush and a handshake both restart at pc_in; flush wins either way.
                if (flush || inst_ready) begin
                    state_next  = ST_WAIT;
                    load_addr   = 1'b1;
                    timer_clear = 1'b1;
                end
            end

            ST_ERR: begin
                state_next = ST_ERR;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_addr <= '0;
            inst_out  <= NOP;
            inst_pc   <= '0;
        end else begin
            if (load_addr) begin
                imem_addr <= pc_in;
            end
            if (capture) begin
                inst_out <= imem_rdata;
                inst_pc  <= imem_addr;
            end
        end
    end

    assign imem_req    = req_state(state);
    assign inst_valid  = (state == ST_FULL);
    assign fetch_stall = (state != ST_IDLE);
    assign fetch_err   = (state == ST_ERR);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, hand-written
// corner sequences, a TIMEOUT=4 instance, and randomized traffic vs a model.
module tb_inst_fetch;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_stall;
    logic        fetch_err;

    logic        t4_rst;
    logic [31:0] t4_pc;
    logic        t4_flush;
    logic        t4_req;
    logic [31:0] t4_addr;
    logic        t4_ack;
    logic [31:0] t4_rdata;
    logic        t4_valid;
    logic        t4_ready;
    logic [31:0] t4_inst;
    logic [31:0] t4_ipc;
    logic        t4_stall;
    logic        t4_err;

    int tests;
    int failed;

    inst_fetch #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc), .fetch_stall(fetch_stall),
        .fetch_err(fetch_err)
    );

    inst_fetch #(.TIMEOUT(4)) dut_t4 (
        .clk(clk), .rst(t4_rst), .pc_in(t4_pc), .flush(t4_flush),
        .imem_req(t4_req), .imem_addr(t4_addr), .imem_ack(t4_ack),
        .imem_rdata(t4_rdata), .inst_valid(t4_valid), .inst_ready(t4_ready),
        .inst_out(t4_inst), .inst_pc(t4_ipc), .fetch_stall(t4_stall),
        .fetch_err(t4_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic fl, input logic ack,
                         input logic [31:0] rd, input logic rdy);
        pc_in      = pc;
        flush      = fl;
        imem_ack   = ack;
        imem_rdata = rd;
        inst_ready = rdy;
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks the fetch as a transaction: started, outstanding read (possibly
    // to be discarded), a held instruction, or a dead memory.
    bit          m_started;
    bit          m_pending;
    bit          m_discard;
    bit          m_hold;
    bit          m_err;
    int          m_wait;
    logic [31:0] m_addr;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;

    task automatic model_reset();
        m_started = 0; m_pending = 0; m_discard = 0; m_hold = 0; m_err = 0;
        m_wait = 0; m_addr = '0; m_inst = '0; m_ipc = '0;
    endtask

    task automatic model_restart(input logic [31:0] pc);
        m_pending = 1; m_discard = 0; m_hold = 0; m_wait = 0; m_addr = pc;
    endtask

    task automatic model_step(input logic [31:0] pc, input logic fl, input logic ack,
                              input logic [31:0] rd, input logic rdy);
        if (m_err) begin
            // dead until reset
        end else if (!m_started) begin
            m_started = 1;
            model_restart(pc);
        end else if (m_hold) begin
            if (fl || rdy) model_restart(pc);
        end else if (ack) begin
            if (m_discard || fl) begin
                model_restart(pc);
            end else begin
                m_hold = 1; m_pending = 0; m_inst = rd; m_ipc = m_addr;
            end
        end else if (fl && !m_discard) begin
            m_discard = 1; m_wait = 0;
        end else begin
            m_wait++;
            if (m_wait >= TMO) begin
                m_err = 1; m_pending = 0;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".req"},   imem_req,    m_pending && !m_err);
        check({tag, ".valid"}, inst_valid,  m_hold);
        check({tag, ".stall"}, fetch_stall, m_started);
        check({tag, ".err"},   fetch_err,   m_err);
        check({tag, ".addr"},  imem_addr,   m_addr);
        if (m_hold) begin
            check({tag, ".inst"}, inst_out, m_inst);
            check({tag, ".ipc"},  inst_pc,  m_ipc);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic        ack;
        logic [31:0] rd;
        logic        rdy;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
        logic [31:0] exp_ipc;
    } vec_t;

    vec_t vecs[14];

    initial begin
        tests = 0;
        failed = 0;
        rst = 1'b1;
        t4_rst = 1'b1;
        t4_pc = 32'h80; t4_flush = 1'b0; t4_ack = 1'b0; t4_rdata = '0; t4_ready = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

        //          pc          fl ack rdata          rdy  req val addr       inst          ipc
        vecs[0]  = '{32'h00, 0, 0, 32'h0,          1,   1, 0, 32'h00, 32'h0,        32'h0};
        vecs[1]  = '{32'h00, 0, 1, 32'h8C010004,   1,   0, 1, 32'h00, 32'h8C010004, 32'h00};
        vecs[2]  = '{32'h04, 0, 0, 32'hFFFFFFFF,   0,   0, 1, 32'h00, 32'h8C010004, 32'h00};
        vecs[3]  = '{32'h04, 0, 0, 32'hFFFFFFFF,   0,   0, 1, 32'h00, 32'h8C010004, 32'h00};
        vecs[4]  = '{32'h04, 0, 0, 32'hFFFFFFFF,   0,   0, 1, 32'h00, 32'h8C010004, 32'h00};
        vecs[5]  = '{32'h04, 0, 0, 32'hFFFFFFFF,   0,   0, 1, 32'h00, 32'h8C010004, 32'h00};
        vecs[6]  = '{32'h04, 0, 0, 32'hFFFFFFFF,   0,   0, 1, 32'h00, 32'h8C010004, 32'h00};
        vecs[7]  = '{32'h04, 0, 0, 32'h0,          1,   1, 0, 32'h04, 32'h0,        32'h0};
        vecs[8]  = '{32'h08, 0, 0, 32'h0,          1,   1, 0, 32'h04, 32'h0,        32'h0};
        vecs[9]  = '{32'h08, 0, 1, 32'h00000013,   0,   0, 1, 32'h04, 32'h00000013, 32'h04};
        vecs[10] = '{32'h10, 1, 0, 32'h0,          1,   1, 0, 32'h10, 32'h0,        32'h0};
        vecs[11] = '{32'h20, 1, 1, 32'h0BADBAD0,   1,   1, 0, 32'h20, 32'h0,        32'h0};
        vecs[12] = '{32'h24, 0, 1, 32'h00000022,   0,   0, 1, 32'h20, 32'h00000022, 32'h20};
        vecs[13] = '{32'h30, 0, 0, 32'h0,          1,   1, 0, 32'h30, 32'h0,        32'h0};

        // Reset state, asynchronous and before any clock edge.
        #3;
        check("rst.req",   imem_req,    1'b0);
        check("rst.valid", inst_valid,  1'b0);
        check("rst.stall", fetch_stall, 1'b0);
        check("rst.err",   fetch_err,   1'b0);
        check("rst.addr",  imem_addr,   32'h0);
        check("rst.inst",  inst_out,    32'h0);
        check("rst.ipc",   inst_pc,     32'h0);
        tick();
        tick();
        rst = 1'b0;
        check("idle.stall", fetch_stall, 1'b0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].pc, vecs[i].fl, vecs[i].ack, vecs[i].rd, vecs[i].rdy);
            tick();
            check($sformatf("vec%0d.req", i),   imem_req,    vecs[i].exp_req);
            check($sformatf("vec%0d.valid", i), inst_valid,  vecs[i].exp_valid);
            check($sformatf("vec%0d.addr", i),  imem_addr,   vecs[i].exp_addr);
            check($sformatf("vec%0d.stall", i), fetch_stall, 1'b1);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d.inst", i), inst_out, vecs[i].exp_inst);
                check($sformatf("vec%0d.ipc", i),  inst_pc,  vecs[i].exp_ipc);
            end
        end

        // flush two cycles into WAIT; the late word must never reach decode.
        drive(32'h30, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        check("drop.req",   imem_req,   1'b1);
        check("drop.addr",  imem_addr,  32'h30);
        check("drop.valid", inst_valid, 1'b0);
        drive(32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        check("drop1.req",   imem_req,   1'b1);
        check("drop1.valid", inst_valid, 1'b0);
        drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("drop2.addr",  imem_addr,  32'h30);
        check("drop2.valid", inst_valid, 1'b0);
        drive(32'h40, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
        tick();
        check("dropack.valid", inst_valid, 1'b0);
        check("dropack.req",   imem_req,   1'b1);
        check("dropack.addr",  imem_addr,  32'h40);
        drive(32'h44, 1'b0, 1'b1, 32'hCAFE0001, 1'b0);
        tick();
        check("refetch.valid", inst_valid, 1'b1);
        check("refetch.inst",  inst_out,   32'hCAFE0001);
        check("refetch.ipc",   inst_pc,    32'h40);

        // Asynchronous reset while holding an instruction.
        drive(32'h100, 1'b0, 1'b1, 32'h1234, 1'b0);
        rst = 1'b1;
        #1;
        check("arst.valid", inst_valid,  1'b0);
        check("arst.inst",  inst_out,    32'h0);
        check("arst.ipc",   inst_pc,     32'h0);
        check("arst.addr",  imem_addr,   32'h0);
        check("arst.stall", fetch_stall, 1'b0);
        tick();
        check("arst.hold", inst_valid, 1'b0);
        rst = 1'b0;
        drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("mid.req",  imem_req,  1'b1);
        check("mid.addr", imem_addr, 32'h100);

        // Reset mid-WAIT; an ack that lands in IDLE is ignored.
        rst = 1'b1;
        #1;
        check("midrst.req", imem_req, 1'b0);
        #2;
        rst = 1'b0;
        drive(32'h200, 1'b0, 1'b1, 32'h0BAD0BAD, 1'b1);
        tick();
        check("late.valid", inst_valid, 1'b0);
        check("late.req",   imem_req,   1'b1);
        check("late.addr",  imem_addr,  32'h200);
        drive(32'h204, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("late2.valid", inst_valid, 1'b0);
        drive(32'h204, 1'b0, 1'b1, 32'h0000600D, 1'b0);
        tick();
        check("resume.valid", inst_valid, 1'b1);
        check("resume.inst",  inst_out,   32'h0000600D);
        check("resume.ipc",   inst_pc,    32'h200);

        // Timeout on the TIMEOUT=4 instance.
        t4_rst = 1'b0;
        tick();
        check("t4.req0", t4_req, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("t4.err_w%0d", i), t4_err, 1'b0);
            check($sformatf("t4.req_w%0d", i), t4_req, 1'b1);
        end
        tick();
        check("t4.err",   t4_err,   1'b1);
        check("t4.req",   t4_req,   1'b0);
        check("t4.valid", t4_valid, 1'b0);
        for (int i = 0; i < 6; i++) begin
            t4_ack = i[0];
            tick();
            check($sformatf("t4.sticky%0d", i), t4_err, 1'b1);
        end
        t4_rst = 1'b1;
        #1;
        check("t4.clr", t4_err, 1'b0);

        // Randomized traffic against the reference model.
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
        compare_model("rnd_rst");
        for (int c = 0; c < 600; c++) begin
            logic [31:0] pc;
            logic        fl, ack, rdy;
            logic [31:0] rd;
            pc  = $urandom() & 32'hFFFF_FFFC;
            fl  = ($urandom_range(0, 9) == 0);
            ack = ($urandom_range(0, 9) < 4);
            rdy = ($urandom_range(0, 9) < 6);
            rd  = $urandom();
            if (c >= 300 && c < 330) ack = 1'b0;  // long stall exercises the timeout
            drive(pc, fl, ack, rd, rdy);
            model_step(pc, fl, ack, rd, rdy);
            tick();
            compare_model($sformatf("rnd%0d", c));
            if (m_err) begin
                rst = 1'b1;
                model_reset();
                #2;
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
